spi_slave_port: RTL and testbench
=================================

# spi_slave_port

SPI responder (slave) that sits at the far end of the team's SPI master serializer and lets a peripheral be driven by an external SPI master. It oversamples SCLK, SS_n and MOSI in the PCLK domain, deserializes MOSI into bytes and serializes a byte-wide transmit holding register onto MISO. It supports all four CPOL/CPHA modes and LSB-first or MSB-first bit order.

## Interface
- No parameters. Byte width is fixed at 8.
- PCLK  in  1  system clock; all logic is on its rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cpol, cpha, lsbfe  in  1 each  SPI mode and bit order; must be static while ss_n is low.
- sclk, ss_n, mosi  in  1 each  asynchronous SPI pins.
- tx_data  in  8  byte to transmit.
- tx_load  in  1  one-cycle write strobe for the transmit holding register.
- tx_ready  out  1  holding register empty.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- miso  out  1  serial data out.
- miso_oe  out  1  MISO output enable; equals the synchronized select.
- busy  out  1  synchronized select is active.
- tx_underrun  out  1  present only with the macro (see Configuration).

## Operation
- Synchronizers:
  - sclk, ss_n and mosi each pass through 2 flip-flops, plus a third stage on sclk and ss_n for edge detection.
  - Reset values: ss_n stages 1, sclk and mosi stages 0.
- Edge definitions:
  - Leading edge: sclk leaves its idle level (cpol=0 rising, cpol=1 falling).
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge.
  - Edges are honoured only while the synchronized ss_n is low.
- States:
  - IDLE: synchronized ss_n is high.
  - ACTIVE: synchronized ss_n is low.
  - IDLE->ACTIVE on the synchronized falling edge of ss_n. This clears bit_cnt. If cpha=0, it also loads the shift register.
  - ACTIVE->IDLE on the synchronized rising edge of ss_n. This clears bit_cnt and discards a partial byte: no rx_valid pulse, rx_data unchanged.
- Receive, on each sample event:
  - lsbfe=1: rx_shift <= {mosi_s, rx_shift[7:1]}. lsbfe=0: {rx_shift[6:0], mosi_s}.
  - bit_cnt increments modulo 8.
  - On the 8th sample, rx_data takes the completed byte and rx_valid pulses in the same cycle. bit_cnt wraps to 0.
- Transmit, on each shift event:
  - If bit_cnt==0, "load" the shift register. Otherwise shift by one toward the output bit, filling with 0.
  - miso is tx_shift[0] if lsbfe, else tx_shift[7].
- Load:
  - The shift register takes tx_hold if it is full, else 8'h00.
  - tx_hold is marked empty, so tx_ready goes to 1.
- tx_load:
  - Writes tx_hold and clears tx_ready.
  - A write while tx_ready=0 overwrites the held byte (last write wins).
  - tx_load in the same cycle as a load: the shift register takes the old content (or 8'h00 if empty), tx_hold takes the new tx_data, and tx_ready stays 0.
- Reset values: miso 0, miso_oe 0, busy 0, rx_data 8'h00, rx_valid 0, tx_ready 1, tx_hold empty, bit_cnt 0, tx_underrun 0.
- Reset mid-transfer aborts the transfer with no rx_valid pulse.

## Timing
- An edge on a pin causes its register action on the 3rd PCLK rising edge after first capture.
- MISO therefore lags the SCLK shift edge by at most 4 PCLK cycles.
- Requirement on the master: SCLK high and low phases are each at least 4 PCLK cycles, and ss_n setup before the first edge is at least 4 PCLK cycles.
- Under this requirement, sample and shift events never coincide.
- rx_valid is exactly 1 cycle wide. rx_data holds until the next completed byte.
- cpha=0: the first bit is on MISO 3 cycles after the ss_n fall.
- cpha=1: the first bit appears after the first leading edge.

## Configuration
- SPI_SLAVE_UNDERRUN_EN defined:
  - Adds output tx_underrun, a sticky flag set when a load finds tx_hold empty.
  - It is cleared by tx_load or PRESET.
- SPI_SLAVE_UNDERRUN_EN undefined:
  - The port and its logic are absent.
  - Empty loads still send 8'h00.

## Test plan
- Mode 0, MSB-first: tx_load 8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready=1 after load.
- Mode 3, LSB-first: tx_load 8'h81, master sends 8'hF0 -> MISO bits 1,0,0,0,0,0,0,1; rx_data=8'hF0.
- Modes 1 and 2: two back-to-back bytes 8'h12, 8'h34 with tx_load of 8'hC3 between them -> two rx_valid pulses; second MISO byte is 8'hC3.
- Deselect after 5 bits -> no rx_valid, rx_data unchanged, miso_oe=0; a following full byte receives correctly.
- No tx_load before select -> MISO sends 8'h00; tx_underrun=1 (with macro) until the next tx_load.
- PRESET mid-byte -> all outputs at reset values next cycle; a subsequent transfer works.

Source files
------------

// File: rtl/spi_slave_port_if.sv
// Bus bundle for spi_slave_port: SPI pins, mode controls and the byte-side handshake.
// With SPI_SLAVE_UNDERRUN_EN defined the bundle also carries tx_underrun.
interface spi_slave_port_if;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       miso;
  logic       miso_oe;
  logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  modport slave (
    input  cpol, cpha, lsbfe, sclk, ss_n, mosi, tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, miso, miso_oe, busy
`ifdef SPI_SLAVE_UNDERRUN_EN
    , output tx_underrun
`endif
  );

  modport master (
    output cpol, cpha, lsbfe, sclk, ss_n, mosi, tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, miso, miso_oe, busy
`ifdef SPI_SLAVE_UNDERRUN_EN
    , input tx_underrun
`endif
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI responder oversampling SCLK/SS_n/MOSI in the PCLK domain; all four modes, either bit order.
// Optional sticky tx_underrun flag is built when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave_port (
  input logic            PCLK,
  input logic            PRESET,
  spi_slave_port_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [2:0] sclk_sync_q;
  logic [2:0] ss_sync_q;
  logic [1:0] mosi_sync_q;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       hold_full_q, hold_full_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun_q, underrun_d;
`endif

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       ss_fall, ss_rise, sel_active;
  logic       sample_ev, shift_ev, load_ev;
  logic [7:0] rx_next;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
      ss_sync_q   <= {ss_sync_q[1:0], bus.ss_n};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
    end
  end

  // Stage 1 is the synchronized level, stage 2 its previous value for edge detection.
  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign lead_edge  = bus.cpol ? sclk_fall : sclk_rise;
  assign trail_edge = bus.cpol ? sclk_rise : sclk_fall;
  assign ss_fall    = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];
  assign sel_active = (state_q == ACTIVE) & ~ss_sync_q[1];
  assign sample_ev  = sel_active & (bus.cpha ? trail_edge : lead_edge);
  assign shift_ev   = sel_active & (bus.cpha ? lead_edge : trail_edge);
  assign load_ev    = ((state_q == IDLE) & ss_fall & ~bus.cpha) |
                      (shift_ev & (bit_cnt_q == 3'd0));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    hold_full_d = hold_full_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d  = underrun_q;
`endif
    rx_next     = bus.lsbfe ? {mosi_sync_q[1], rx_shift_q[7:1]}
                            : {rx_shift_q[6:0], mosi_sync_q[1]};

    if ((state_q == IDLE) && ss_fall) begin
      state_d   = ACTIVE;
      bit_cnt_d = 3'd0;
    end else if ((state_q == ACTIVE) && ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end

    if (sample_ev) begin
      rx_shift_d = rx_next;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
      end
    end

    if (shift_ev && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = bus.lsbfe ? {1'b0, tx_shift_q[7:1]} : {tx_shift_q[6:0], 1'b0};
    end

    if (load_ev) begin
      tx_shift_d  = hold_full_q ? tx_hold_q : 8'h00;
      hold_full_d = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (!hold_full_q) underrun_d = 1'b1;
`endif
    end

    // A write coinciding with a load refills the register the load just drained.
    if (bus.tx_load) begin
      tx_hold_d   = bus.tx_data;
      hold_full_d = 1'b1;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      hold_full_q <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      hold_full_q <= hold_full_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= underrun_d;
`endif
    end
  end

  assign bus.miso     = bus.lsbfe ? tx_shift_q[0] : tx_shift_q[7];
  assign bus.miso_oe  = (state_q == ACTIVE);
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
  assign bus.tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a behavioural SPI master drives the pins, a scoreboard checks
// received bytes and MISO bytes against a byte-level model of the holding register.
module tb_spi_slave_port;

  localparam int H = 7;

  logic PCLK = 1'b0;
  logic PRESET;
  spi_slave_port_if bus();

  spi_slave_port dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  int nVec = 0;
  int nBad = 0;

  // Byte-level model: holding register contents, sticky underrun, last received byte.
  logic       mHoldFull;
  logic [7:0] mHold;
  logic       mUnder;
  logic [7:0] mLastRx;

  logic [7:0] expRx[$];
  logic [7:0] expMiso[$];
  logic [7:0] misoObs[$];

  logic [7:0] mosiBuf[4];
  bit         ldEn[32];
  logic [7:0] ldVal[32];

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge PCLK);
    #2;
  endtask

  function automatic logic [7:0] modelLoad();
    logic [7:0] r;
    r = mHoldFull ? mHold : 8'h00;
    if (!mHoldFull) mUnder = 1'b1;
    mHoldFull = 1'b0;
    return r;
  endfunction

  task automatic modelReset();
    mHoldFull = 1'b0;
    mHold     = 8'h00;
    mUnder    = 1'b0;
    mLastRx   = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input logic expBusy);
    checkValue({tag, ".busy"},     {7'b0, bus.busy},     {7'b0, expBusy});
    checkValue({tag, ".miso_oe"},  {7'b0, bus.miso_oe},  {7'b0, expBusy});
    checkValue({tag, ".tx_ready"}, {7'b0, bus.tx_ready}, {7'b0, ~mHoldFull});
    checkValue({tag, ".rx_data"},  bus.rx_data,          mLastRx);
`ifdef SPI_SLAVE_UNDERRUN_EN
    checkValue({tag, ".tx_underrun"}, {7'b0, bus.tx_underrun}, {7'b0, mUnder});
`endif
  endtask

  task automatic txLoad(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    mHold       = v;
    mHoldFull   = 1'b1;
    mUnder      = 1'b0;
    waitCycles(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic setMode(input logic cpol, input logic cpha, input logic lsbfe);
    bus.cpol  = cpol;
    bus.cpha  = cpha;
    bus.lsbfe = lsbfe;
    bus.sclk  = cpol;
    waitCycles(6);
  endtask

  task automatic clearLoads();
    for (int i = 0; i < 32; i++) begin
      ldEn[i]  = 1'b0;
      ldVal[i] = 8'h00;
    end
  endtask

  // Half phase following a sample edge; the only safe window for a tx_load write.
  task automatic halfWithLoad(input int i);
    waitCycles(4);
    if (ldEn[i]) txLoad(ldVal[i]);
    else waitCycles(1);
    waitCycles(H - 5);
  endtask

  task automatic doReset();
    PRESET   = 1'b1;
    bus.ss_n = 1'b1;
    bus.sclk = bus.cpol;
    bus.mosi = 1'b0;
    waitCycles(1);
    modelReset();
    checkOutput("reset", 1'b0);
    checkValue("reset.miso",     {7'b0, bus.miso},     8'h00);
    checkValue("reset.rx_valid", {7'b0, bus.rx_valid}, 8'h00);
    waitCycles(3);
    PRESET = 1'b0;
    waitCycles(4);
  endtask

  // One select period of nbits bits taken from mosiBuf; optional PRESET instead of deselect.
  task automatic applyStimulus(input int nbits, input bit abortReset);
    int nFull;
    logic [7:0] obs, v;
    logic m, b;
    nFull = nbits / 8;
    obs = 8'h00;
    for (int j = 0; j < nFull; j++) expRx.push_back(mosiBuf[j]);
    bus.ss_n = 1'b0;
    if (!bus.cpha) begin
      v = modelLoad();
      if (nFull > 0) expMiso.push_back(v);
    end
    waitCycles(H);
    for (int i = 0; i < nbits; i++) begin
      int j, k;
      j = i / 8;
      k = i % 8;
      b = bus.lsbfe ? mosiBuf[j][k] : mosiBuf[j][7-k];
      if (bus.cpha) begin
        bus.sclk = ~bus.cpol;
        bus.mosi = b;
        if (k == 0) begin
          v = modelLoad();
          if (j < nFull) expMiso.push_back(v);
        end
        waitCycles(H);
        m = bus.miso;
        bus.sclk = bus.cpol;
        halfWithLoad(i);
      end else begin
        bus.mosi = b;
        waitCycles(H);
        m = bus.miso;
        bus.sclk = ~bus.cpol;
        halfWithLoad(i);
        bus.sclk = bus.cpol;
        if (k == 7) begin
          v = modelLoad();
          if (j + 1 < nFull) expMiso.push_back(v);
        end
      end
      if (bus.lsbfe) obs[k] = m;
      else obs[7-k] = m;
      if (k == 7) misoObs.push_back(obs);
    end
    if (abortReset) begin
      doReset();
    end else begin
      waitCycles(H);
      bus.ss_n = 1'b1;
      if (nFull > 0) mLastRx = mosiBuf[nFull-1];
      waitCycles(8);
    end
  endtask

  logic [7:0] monE, monO;

  always @(negedge PCLK) begin
    if (bus.rx_valid === 1'b1) begin
      if (expRx.size() == 0) begin
        nVec++;
        nBad++;
        $display("[TB] FAIL rx_unexpected: got rx_valid with rx_data %h, expected no pulse", bus.rx_data);
      end else begin
        monE = expRx.pop_front();
        checkValue("rx_byte", bus.rx_data, monE);
      end
    end
    if (misoObs.size() > 0) begin
      monO = misoObs.pop_front();
      if (expMiso.size() == 0) begin
        nVec++;
        nBad++;
        $display("[TB] FAIL miso_unexpected: got byte %h, expected none", monO);
      end else begin
        monE = expMiso.pop_front();
        checkValue("miso_byte", monO, monE);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET      = 1'b1;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
    bus.lsbfe   = 1'b0;
    bus.sclk    = 1'b0;
    bus.ss_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    modelReset();
    clearLoads();
    waitCycles(3);
    checkOutput("por", 1'b0);
    checkValue("por.miso",     {7'b0, bus.miso},     8'h00);
    checkValue("por.rx_valid", {7'b0, bus.rx_valid}, 8'h00);
    PRESET = 1'b0;
    waitCycles(3);

    $display("[TB] mode 0 MSB-first");
    setMode(1'b0, 1'b0, 1'b0);
    txLoad(8'hA5);
    checkOutput("loaded", 1'b0);
    mosiBuf[0] = 8'h3C;
    applyStimulus(8, 1'b0);
    checkOutput("mode0", 1'b0);

    $display("[TB] mode 3 LSB-first");
    setMode(1'b1, 1'b1, 1'b1);
    txLoad(8'h81);
    mosiBuf[0] = 8'hF0;
    applyStimulus(8, 1'b0);
    checkOutput("mode3", 1'b0);

    $display("[TB] modes 1 and 2 back-to-back");
    for (int md = 0; md < 2; md++) begin
      if (md == 0) setMode(1'b0, 1'b1, 1'b0);
      else setMode(1'b1, 1'b0, 1'b0);
      txLoad(8'h5A);
      mosiBuf[0] = 8'h12;
      mosiBuf[1] = 8'h34;
      clearLoads();
      ldEn[6]  = 1'b1;
      ldVal[6] = 8'hC3;
      applyStimulus(16, 1'b0);
      clearLoads();
      checkOutput("b2b", 1'b0);
    end

    $display("[TB] deselect after 5 bits");
    setMode(1'b0, 1'b0, 1'b1);
    mosiBuf[0] = 8'hE7;
    applyStimulus(5, 1'b0);
    checkOutput("partial", 1'b0);
    txLoad(8'h6B);
    mosiBuf[0] = 8'h4D;
    applyStimulus(8, 1'b0);
    checkOutput("after_partial", 1'b0);

    $display("[TB] empty holding register");
    setMode(1'b0, 1'b1, 1'b0);
    mosiBuf[0] = 8'h99;
    applyStimulus(8, 1'b0);
    checkOutput("underrun", 1'b0);
    txLoad(8'h11);
    checkOutput("underrun_clr", 1'b0);

    $display("[TB] reset mid-byte");
    setMode(1'b0, 1'b0, 1'b0);
    mosiBuf[0] = 8'hB2;
    applyStimulus(4, 1'b1);
    checkOutput("post_reset", 1'b0);
    txLoad(8'h3E);
    mosiBuf[0] = 8'hD9;
    applyStimulus(8, 1'b0);
    checkOutput("after_reset", 1'b0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 20; t++) begin
      int nbytes, nbits;
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) txLoad(8'($urandom));
      nbytes = $urandom_range(1, 3);
      nbits  = nbytes * 8;
      if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
      for (int j = 0; j < 4; j++) mosiBuf[j] = 8'($urandom);
      clearLoads();
      for (int i = 0; i < nbits; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          ldEn[i]  = 1'b1;
          ldVal[i] = 8'($urandom);
        end
      end
      applyStimulus(nbits, 1'b0);
      checkOutput("random", 1'b0);
    end
    clearLoads();

    waitCycles(10);
    checkValue("rx_queue_left",   8'(expRx.size()),   8'h00);
    checkValue("miso_queue_left", 8'(expMiso.size()), 8'h00);
    checkValue("obs_queue_left",  8'(misoObs.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
